mulu: RTL and testbench

Sequential 32x32 multiplier for the CPU_55 datapath, and the multiply counterpart to the `divu` divider. It uses the same `start`/`busy` handshake as `divu`, so the HI/LO control logic can issue MULT/MULTU exactly as it issues DIVU. One radix-2 shift-add iteration runs per clock. The result is a 64-bit product presented as `hi`/`lo`.

---
 rtl/cpu55_pkg.sv | 14 +
 rtl/mulu_if.sv | 32 +++
 rtl/mulu.sv | 114 +++++++++++
 tb/tb_mulu.sv | 130 +++++++++++++
 4 files changed

// File: rtl/cpu55_pkg.sv
// Shared definitions for the CPU_55 HI/LO datapath units (mulu, divu).
// Holds the multiplier geometry and the two-state handshake FSM encoding
// so the HI/LO controller sees the same state view from both units.
package cpu55_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = 5;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

endpackage

// File: rtl/mulu_if.sv
// Request/result bundle for the sequential multiplier.
//   a, b   : operands, sampled on the accepting edge
//   sign   : 1 = signed (MULT), 0 = unsigned (MULTU)
//   start  : level request, honoured only while busy = 0
//   hi, lo : 2*WIDTH-bit product, upper and lower halves
//   busy   : operation in progress
//   ready  : one-cycle pulse when hi/lo are updated
// master = issuing controller, slave = multiplier.
interface mulu_if
    import cpu55_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sign;
    logic             start;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             ready;

    modport master (
        output a, b, sign, start,
        input  hi, lo, busy, ready
    );

    modport slave (
        input  a, b, sign, start,
        output hi, lo, busy, ready
    );
endinterface

// File: rtl/mulu.sv
// Sequential WIDTH x WIDTH radix-2 shift-add multiplier, one iteration
// per clock. Signed operation multiplies the operand magnitudes and
// negates the 2*WIDTH-bit product at the end when the signs differ.
// Ports:
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : mulu_if.slave (a, b, sign, start in; hi, lo, busy, ready out)
// Timing: accepting edge E0, run edges E1..E(WIDTH); on the last run edge
// busy drops, ready pulses and hi/lo take the new product.
module mulu
    import cpu55_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic   clock,
    input  logic   resetn,
    mulu_if.slave  bus
);

    localparam int CNT_W = (WIDTH == MUL_WIDTH) ? MUL_CNT_W : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // Two's-complement magnitude; the most negative value maps onto its
    // own bit pattern, which is the correct unsigned magnitude 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                             input logic             sgn);
        return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    md_state_t          state, state_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   count;
    logic               neg;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               ready_q;

    logic               load, step, done;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] prod;

    // Single WIDTH+1 adder into the upper half; its carry is shifted back
    // in as the new MSB so no product bit is lost.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + {1'b0, (mplier[0] ? mcand : '0)};
        acc_nxt = {sum, acc[WIDTH-1:1]};
        prod    = neg ? (~acc_nxt + (2*WIDTH)'(1)) : acc_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        done      = 1'b0;
        case (state)
            MD_IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = MD_RUN;
                end
            end
            MD_RUN: begin
                step = 1'b1;
                if (count == LAST) begin
                    done      = 1'b1;
                    state_nxt = MD_IDLE;
                end
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= MD_IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            neg     <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= done;
            if (load) begin
                mcand  <= mag(bus.a, bus.sign);
                mplier <= mag(bus.b, bus.sign);
                neg    <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                acc    <= '0;
                count  <= '0;
            end else if (step) begin
                acc    <= acc_nxt;
                mplier <= mplier >> 1;
                count  <= count + CNT_W'(1);
            end
            // Result registers move only on completion; they hold the
            // previous product throughout RUN.
            if (done) begin
                {hi_q, lo_q} <= prod;
            end
        end
    end

    assign bus.busy  = (state == MD_RUN);
    assign bus.ready = ready_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mulu.sv
// Directed self-checking bench for mulu. Outputs are sampled on the
// falling clock edge; inputs are driven there too.
module tb_mulu;
    import cpu55_pkg::*;

    logic clock;
    logic resetn;
    int   tests;
    int   fails;
    int   n;

    mulu_if #(.WIDTH(32)) bus ();

    mulu #(.WIDTH(32)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: requests one operation, counts busy
    // cycles (bounded), then checks the result and the ready pulse.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [31:0] ehi,
                          input logic [31:0] elo, input string tag);
        int cyc;
        bus.a = a; bus.b = b; bus.sign = sgn; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        chk({tag, " busy"}, 64'(bus.busy), 64'd1);
        cyc = 1;
        while (bus.busy && cyc < 40) begin
            @(negedge clock);
            if (bus.busy) cyc++;
        end
        chk({tag, " busy_cycles"}, 64'(cyc), 64'd32);
        chk({tag, " ready"}, 64'(bus.ready), 64'd1);
        chk({tag, " hi"}, 64'(bus.hi), 64'(ehi));
        chk({tag, " lo"}, 64'(bus.lo), 64'(elo));
        @(negedge clock);
        chk({tag, " ready_drop"}, 64'(bus.ready), 64'd0);
    endtask

    initial begin
        tests = 0; fails = 0;
        resetn = 1'b0;
        bus.a = '0; bus.b = '0; bus.sign = 1'b0; bus.start = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst busy",  64'(bus.busy),  64'd0);
        chk("rst ready", 64'(bus.ready), 64'd0);
        chk("rst hi",    64'(bus.hi),    64'd0);
        chk("rst lo",    64'(bus.lo),    64'd0);
        resetn = 1'b1;
        @(negedge clock);

        run_op(32'd3, 32'd5, 1'b0, 32'h0, 32'd15, "multu 3x5");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
               32'hFFFF_FFFE, 32'h0000_0001, "multu max");
        run_op(32'hFFFF_FFFF, 32'd2, 1'b1,
               32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult -1x2");
        run_op(32'd5, 32'hFFFF_FFFD, 1'b1,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult 5x-3");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1,
               32'h4000_0000, 32'h0, "mult minneg");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0,
               32'h4000_0000, 32'h0, "multu 2^31");
        run_op(32'd0, 32'd0, 1'b0, 32'h0, 32'h0, "multu zero");

        // Back-to-back with start held; operand change during busy must
        // not affect the running operation.
        bus.a = 32'd7; bus.b = 32'd9; bus.sign = 1'b0; bus.start = 1'b1;
        @(negedge clock);
        bus.a = 32'd55; bus.b = 32'd2;
        chk("b2b busy", 64'(bus.busy), 64'd1);
        n = 1;
        while (bus.busy && n < 40) begin
            @(negedge clock);
            if (bus.busy) n++;
        end
        chk("b2b first cycles", 64'(n), 64'd32);
        chk("b2b first ready", 64'(bus.ready), 64'd1);
        chk("b2b first lo", 64'(bus.lo), 64'd63);
        @(negedge clock);
        chk("b2b restart busy", 64'(bus.busy), 64'd1);
        chk("b2b restart ready", 64'(bus.ready), 64'd0);
        bus.start = 1'b0;
        repeat (5) @(negedge clock);
        chk("b2b hold lo", 64'(bus.lo), 64'd63);
        n = 6;
        while (bus.busy && n < 40) begin
            @(negedge clock);
            if (bus.busy) n++;
        end
        chk("b2b second cycles", 64'(n), 64'd32);
        chk("b2b second ready", 64'(bus.ready), 64'd1);
        chk("b2b second lo", 64'(bus.lo), 64'd110);

        // Reset mid-run, then a clean operation on the first edge after
        // reset release.
        @(negedge clock);
        bus.a = 32'd3; bus.b = 32'd5; bus.sign = 1'b0; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (9) @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("abort busy",  64'(bus.busy),  64'd0);
        chk("abort ready", 64'(bus.ready), 64'd0);
        chk("abort hi",    64'(bus.hi),    64'd0);
        chk("abort lo",    64'(bus.lo),    64'd0);
        @(negedge clock);
        resetn = 1'b1;
        run_op(32'd4, 32'd4, 1'b0, 32'h0, 32'd16, "post-reset 4x4");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
